// File: rtl/rom_bus_server_pkg.sv
// Shared types and constants for the ROM bus server: FSM state encoding and
// the default base address of the CPU ROM window.
package rom_bus_server_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam logic [15:0] ROM_BASE_DEFAULT = 16'h8000;

endpackage

// File: rtl/rom_bus_server_phi2_sync.sv
// Brings the asynchronous CPU phi2 into the clk domain and detects its edges.
// Bit 0 is the first synchroniser stage, bit 1 the second, bit 2 the edge flop.
module phi2_sync (
  input  logic clk,
  input  logic rst,
  input  logic phi2_in,
  output logic phi2_rise,
  output logic phi2_fall,
  output logic phi2_level,
  output logic phi2_fall_pending
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], phi2_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign phi2_rise  = sync_q[1] & ~sync_q[2];
  assign phi2_fall  = ~sync_q[1] & sync_q[2];
  assign phi2_level = sync_q[1];
  // Stage 1 already low while stage 2 is high: a fall is one edge away.
  assign phi2_fall_pending = sync_q[1] & ~sync_q[0];

endmodule

// File: rtl/rom_bus_server.sv
// Shared ROM RAM owner: passes loader writes through, holds the 6502 in reset
// until the image is loaded plus a hold time, then serves CPU ROM-window reads.
module rom_bus_server
  import rom_bus_server_pkg::*;
#(
  parameter logic [15:0] ROM_BASE          = ROM_BASE_DEFAULT,
  parameter int unsigned RESET_HOLD_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ld_address,
  input  logic [7:0]  ld_datain,
  input  logic        ld_cs,
  input  logic        ld_we,
  input  logic        ld_complete,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        cpu_phi2,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  output logic        cpu_reset_n,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_datain,
  output logic        ram_cs,
  output logic        ram_we,
  input  logic [7:0]  ram_dataout,
  output state_e      dbg_state
);

  localparam int CW = (RESET_HOLD_CYCLES > 2) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RESET_HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic          cs_q, cs_d;
  logic [7:0]    data_q, data_d;
  logic          oe_q, oe_d;
  logic          reset_n_q, reset_n_d;

  logic phi2_rise, phi2_fall, phi2_level, phi2_fall_pending;

  phi2_sync u_phi2_sync (
    .clk               (clk),
    .rst               (rst),
    .phi2_in           (cpu_phi2),
    .phi2_rise         (phi2_rise),
    .phi2_fall         (phi2_fall),
    .phi2_level        (phi2_level),
    .phi2_fall_pending (phi2_fall_pending)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cs_d    = 1'b0;
    data_d  = data_q;
    oe_d    = oe_q;
    case (state_q)
      S_LOAD: begin
        if (ld_complete) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (phi2_rise && cpu_rw && (cpu_addr >= ROM_BASE)) begin
          addr_d = cpu_addr;
          cs_d   = 1'b1;
        end
        // Capture always lands; the bus is only driven if phi2 is still high.
        if (cs_q) begin
          data_d = ram_dataout;
          oe_d   = phi2_level & ~phi2_fall_pending;
        end else if (phi2_fall) begin
          oe_d = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
    reset_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      addr_q    <= 16'h0000;
      cs_q      <= 1'b0;
      data_q    <= 8'h00;
      oe_q      <= 1'b0;
      reset_n_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
      reset_n_q <= reset_n_d;
    end
  end

  always_comb begin
    if (state_q == S_LOAD) begin
      ram_address = ld_address;
      ram_datain  = ld_datain;
      ram_cs      = ld_cs;
      ram_we      = ld_we;
    end else begin
      ram_address = addr_q;
      ram_datain  = 8'h00;
      ram_cs      = cs_q;
      ram_we      = 1'b0;
    end
  end

  assign cpu_data_out = data_q;
  assign cpu_data_oe  = oe_q;
  assign cpu_reset_n  = reset_n_q;
  assign dbg_state    = state_q;

endmodule
